alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: W, 32, operand/result width in bits.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 a_valid  input  1  requester A has an operation pending.
REQ-005 a_ready  output  1  requester A operation accepted this cycle.
REQ-006 a_op1, a_op2  input  W  requester A operands.
REQ-007 a_sel  input  4  requester A ALU select code.
REQ-008 b_valid, b_ready, b_op1, b_op2, b_sel  same directions/widths/meanings as A, for requester B.
REQ-009 alu_op1, alu_op2  output  W  operands driven to the shared ALU.
REQ-010 alu_sel  output  4  select driven to the shared ALU.
REQ-011 alu_res  input  W  ALU result (combinational from alu_op1/op2/sel).
REQ-012 alu_zero  input  1  ALU zero flag.
REQ-013 rsp_valid  output  1  response holds a completed result.
REQ-014 rsp_ready  input  1  consumer accepts response this cycle.
REQ-015 rsp_id  output  1  0 = result belongs to A, 1 = to B.
REQ-016 rsp_result  output  W  registered ALU result.
REQ-017 rsp_zero  output  1  registered ALU zero flag.
REQ-018 busy  output  1  high whenever state is not IDLE.

Function
REQ-019 FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-020 IDLE: a_ready/b_ready SHALL be combinational grants; at most one high; only when corresponding valid is high.
REQ-021 Only one valid high in IDLE -> that requester SHALL be granted.
REQ-022 Both valid high in IDLE -> grant SHALL go to requester not granted most recently (round-robin via last_grant register).
REQ-023 On grant edge: op1, op2, sel, id SHALL be latched into internal registers; state -> EXEC.
REQ-024 IDLE with no valid -> SHALL remain IDLE; no ready asserted.
REQ-025 a_ready and b_ready SHALL be 0 in EXEC and RESP regardless of valids.
REQ-026 alu_op1/alu_op2/alu_sel SHALL always be driven from the latched registers (stable across EXEC and RESP).
REQ-027 EXEC lasts exactly one cycle; at its end edge alu_res -> rsp_result, alu_zero -> rsp_zero, latched id -> rsp_id; state -> RESP.
REQ-028 RESP: rsp_valid SHALL be 1; rsp_result/rsp_zero/rsp_id SHALL be stable until handshake.
REQ-029 RESP with rsp_ready=1 -> state -> IDLE next edge; rsp_valid 0 in IDLE and EXEC.
REQ-030 RESP with rsp_ready=0 -> SHALL stay in RESP indefinitely (backpressure).
REQ-031 Latency: grant at edge N -> rsp_valid high in cycle after edge N+1; minimum issue interval 3 cycles.
REQ-032 last_grant SHALL update only on a grant edge.
REQ-033 Result data SHALL pass through unmodified; no width change, no sign handling in this block.
REQ-034 Unsupported sel codes SHALL be forwarded unchanged (ALU defines result).

Reset
REQ-035 reset high SHALL force IDLE immediately, regardless of clk, from any state.
REQ-036 Reset values: rsp_valid 0, rsp_id 0, rsp_result 0, rsp_zero 0, busy 0, latched op1/op2 0, latched sel 0, last_grant = B (A wins first tie).
REQ-037 Reset mid-EXEC or mid-RESP SHALL discard the in-flight operation; no response issued.

Verification
REQ-038 A only: a_op1=5, a_op2=3, a_sel=0010 -> a_ready 1 for one cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_result=8, rsp_zero=0.
REQ-039 Both valid after reset: A sel=0110 7-7, B sel=0001 0xF0|0x0F -> first response id=0 result 0 zero 1; second id=1 result 0xFF zero 0.
REQ-040 Both valid held continuously for 4 operations -> grant order A,B,A,B.
REQ-041 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_result stable, a_ready/b_ready stay 0; release -> IDLE next edge.
REQ-042 reset pulsed asynchronously during EXEC -> rsp_valid 0, busy 0 immediately; no response after reset release.
REQ-043 Changing a_op1 while in EXEC/RESP -> alu_op1 and rsp_result unaffected.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Each accepted operation is held one cycle in EXEC, then presented as a registered response.
module alu_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [W-1:0] a_op1,
  input  logic [W-1:0] a_op2,
  input  logic [3:0]   a_sel,
  input  logic         b_valid,
  output logic         b_ready,
  input  logic [W-1:0] b_op1,
  input  logic [W-1:0] b_op2,
  input  logic [3:0]   b_sel,
  output logic [W-1:0] alu_op1,
  output logic [W-1:0] alu_op2,
  output logic [3:0]   alu_sel,
  input  logic [W-1:0] alu_res,
  input  logic         alu_zero,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_result,
  output logic         rsp_zero,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state_q, state_d;
  logic           last_grant;   // 0 = A granted last, 1 = B
  logic           grant;
  logic           grant_id;
  logic           id_q;
  logic [W-1:0]   op1_q, op2_q;
  logic [3:0]     sel_q;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    grant    = 1'b0;
    grant_id = 1'b0;
    case (state_q)
      IDLE: begin
        // A wins when alone, or on a tie when B had the previous grant.
        if (a_valid && (!b_valid || last_grant)) begin
          a_ready  = 1'b1;
          grant    = 1'b1;
          grant_id = 1'b0;
        end else if (b_valid) begin
          b_ready  = 1'b1;
          grant    = 1'b1;
          grant_id = 1'b1;
        end
        if (grant) state_d = EXEC;
      end
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      op1_q      <= '0;
      op2_q      <= '0;
      sel_q      <= '0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        op1_q      <= grant_id ? b_op1 : a_op1;
        op2_q      <= grant_id ? b_op2 : a_op2;
        sel_q      <= grant_id ? b_sel : a_sel;
        id_q       <= grant_id;
        last_grant <= grant_id;
      end
      if (state_q == EXEC) begin
        rsp_result <= alu_res;
        rsp_zero   <= alu_zero;
        rsp_id     <= id_q;
      end
    end
  end

  assign alu_op1   = op1_q;
  assign alu_op2   = op2_q;
  assign alu_sel   = sel_q;
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU attached to the shared port.
module tb_alu_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         a_valid, b_valid;
  logic         a_ready, b_ready;
  logic [W-1:0] a_op1, a_op2, b_op1, b_op2;
  logic [3:0]   a_sel, b_sel;
  logic [W-1:0] alu_op1, alu_op2, alu_res;
  logic [3:0]   alu_sel;
  logic         alu_zero;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
  logic [W-1:0] rsp_result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.W(W)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_op1(a_op1), .a_op2(a_op2), .a_sel(a_sel),
    .b_valid(b_valid), .b_ready(b_ready), .b_op1(b_op1), .b_op2(b_op2), .b_sel(b_sel),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel),
    .alu_res(alu_res), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy)
  );

  // Shared ALU: AND, OR, ADD, SUB; anything else yields XOR.
  always_comb begin
    case (alu_sel)
      4'b0000: alu_res = alu_op1 & alu_op2;
      4'b0001: alu_res = alu_op1 | alu_op2;
      4'b0010: alu_res = alu_op1 + alu_op2;
      4'b0110: alu_res = alu_op1 - alu_op2;
      default: alu_res = alu_op1 ^ alu_op2;
    endcase
  end
  assign alu_zero = (alu_res == '0);

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in IDLE with valids already driven; runs one full grant/exec/response with rsp_ready high.
  task automatic do_op(input string tag, input logic id, input logic [W-1:0] res, input logic zero);
    #1;
    check({tag, "_a_ready"}, W'(a_ready), W'(id == 1'b0));
    check({tag, "_b_ready"}, W'(b_ready), W'(id == 1'b1));
    tick();
    check({tag, "_exec_busy"}, W'(busy), 1);
    check({tag, "_exec_rdy"}, W'(a_ready | b_ready), 0);
    check({tag, "_exec_rsp_valid"}, W'(rsp_valid), 0);
    tick();
    check({tag, "_rsp_valid"}, W'(rsp_valid), 1);
    check({tag, "_rsp_id"}, W'(rsp_id), W'(id));
    check({tag, "_rsp_result"}, rsp_result, res);
    check({tag, "_rsp_zero"}, W'(rsp_zero), W'(zero));
    tick();
    check({tag, "_idle_rsp_valid"}, W'(rsp_valid), 0);
  endtask

  initial begin
    reset = 1'b1; a_valid = 0; b_valid = 0; rsp_ready = 0;
    a_op1 = 0; a_op2 = 0; a_sel = 0; b_op1 = 0; b_op2 = 0; b_sel = 0;
    #12;
    check("rst_busy", W'(busy), 0);
    check("rst_rsp_valid", W'(rsp_valid), 0);
    check("rst_rsp_id", W'(rsp_id), 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_zero", W'(rsp_zero), 0);
    check("rst_alu_op1", alu_op1, 0);
    check("rst_alu_sel", W'(alu_sel), 0);
    check("rst_ready", W'(a_ready | b_ready), 0);
    reset = 1'b0;
    tick();

    // Idle with no requests stays idle
    tick();
    check("idle_busy", W'(busy), 0);
    check("idle_ready", W'(a_ready | b_ready), 0);

    // A alone: 5 + 3; a_op1 changes while in flight
    a_valid = 1; a_op1 = 5; a_op2 = 3; a_sel = 4'b0010;
    #1;
    check("a_only_a_ready", W'(a_ready), 1);
    check("a_only_b_ready", W'(b_ready), 0);
    tick();
    a_valid = 0; a_op1 = 100;
    #1;
    check("a_only_exec_busy", W'(busy), 1);
    check("a_only_exec_ready", W'(a_ready), 0);
    check("a_only_hold_op1", alu_op1, 5);
    tick();
    check("a_only_rsp_valid", W'(rsp_valid), 1);
    check("a_only_rsp_id", W'(rsp_id), 0);
    check("a_only_rsp_result", rsp_result, 8);
    check("a_only_rsp_zero", W'(rsp_zero), 0);
    check("a_only_hold_op1_resp", alu_op1, 5);
    rsp_ready = 1;
    tick();
    check("a_only_idle_valid", W'(rsp_valid), 0);
    check("a_only_idle_busy", W'(busy), 0);

    // Fresh reset so A wins the first tie; both held for four operations
    reset = 1'b1; #2; reset = 1'b0;
    tick();
    a_valid = 1; a_op1 = 7; a_op2 = 7; a_sel = 4'b0110;
    b_valid = 1; b_op1 = 32'hF0; b_op2 = 32'h0F; b_sel = 4'b0001;
    do_op("rr1", 1'b0, 0, 1'b1);
    do_op("rr2", 1'b1, 32'hFF, 1'b0);
    do_op("rr3", 1'b0, 0, 1'b1);
    do_op("rr4", 1'b1, 32'hFF, 1'b0);

    // Backpressure: A wins tie (B granted last), 10 + 20 held for 5 cycles
    rsp_ready = 0;
    a_op1 = 10; a_op2 = 20; a_sel = 4'b0010;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", W'(rsp_valid), 1);
      check("bp_rsp_result", rsp_result, 30);
      check("bp_rsp_id", W'(rsp_id), 0);
      check("bp_ready", W'(a_ready | b_ready), 0);
      tick();
    end
    rsp_ready = 1;
    tick();
    check("bp_release_valid", W'(rsp_valid), 0);
    check("bp_release_busy", W'(busy), 0);
    check("bp_next_b_ready", W'(b_ready), 1);
    check("bp_next_a_ready", W'(a_ready), 0);
    a_valid = 0; b_valid = 0;

    // Unsupported select forwarded, then async reset mid-EXEC discards the op
    a_valid = 1; a_op1 = 32'h3; a_op2 = 32'h5; a_sel = 4'b1111;
    tick();
    a_valid = 0;
    check("fwd_sel", W'(alu_sel), 32'hF);
    check("rst_exec_busy_before", W'(busy), 1);
    #2 reset = 1'b1;
    #1;
    check("rst_exec_busy", W'(busy), 0);
    check("rst_exec_rsp_valid", W'(rsp_valid), 0);
    check("rst_exec_alu_sel", W'(alu_sel), 0);
    #2 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_rsp_valid", W'(rsp_valid), 0);
      check("post_rst_busy", W'(busy), 0);
    end
    check("post_rst_rsp_result", rsp_result, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
